// File: rtl/framebuffer_writer_pkg.sv
// Shared pixel-pipeline types for the double-buffered framebuffer writer.
// Define FB_CLEAR_EN to add the CLEAR state that fills the back bank after reset and each swap.
package framebuffer_writer_pkg;

  // Metadata coordinates are wide enough for framebuffers up to 1024x1024.
  localparam int unsigned COORD_W = 10;

  typedef logic [11:0] pixel_data_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               frame_last;
  } pixel_metadata_t;

  typedef enum logic [1:0] {
    ST_DRAW      = 2'd0,
`ifdef FB_CLEAR_EN
    ST_CLEAR     = 2'd2,
`endif
    ST_WAIT_SWAP = 2'd1
  } fb_state_t;

endpackage

// File: rtl/framebuffer_writer_if.sv
// Pixel beat stream: colour plus (x, y, frame_last) metadata with valid/ready handshake.
interface framebuffer_writer_if;
  import framebuffer_writer_pkg::*;

  logic            valid;
  logic            ready;
  pixel_data_t     data;
  pixel_metadata_t metadata;

  modport master (output valid, output data, output metadata, input ready);
  modport slave  (input valid, input data, input metadata, output ready);
endinterface

// File: rtl/framebuffer_writer_fb_bank.sv
// One framebuffer bank: simple dual-port RAM, one write port, registered read port.
module fb_bank
  import framebuffer_writer_pkg::*;
#(
  parameter int unsigned DEPTH = 19200,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  pixel_data_t   wr_data,
  input  logic [AW-1:0] rd_addr,
  output pixel_data_t   rd_data
);

  pixel_data_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/framebuffer_writer.sv
// Double-buffered framebuffer writer: draws into the back bank, scans out the front bank,
// swaps on vblank after frame_last. FB_CLEAR_EN enables the back-bank clear pass.
module framebuffer_writer
  import framebuffer_writer_pkg::*;
#(
  parameter int unsigned BUFFER_WIDTH  = 160,
  parameter int unsigned BUFFER_HEIGHT = 120,
  parameter pixel_data_t CLEAR_COLOR   = 12'h000
) (
  input  logic                             clk,
  input  logic                             rst,
  framebuffer_writer_if.slave              pixel_s,
  input  logic                             vblank_start,
  input  logic [$clog2(BUFFER_WIDTH)-1:0]  scan_x,
  input  logic [$clog2(BUFFER_HEIGHT)-1:0] scan_y,
  output pixel_data_t                      scan_color,
  output logic                             front_sel,
  output logic [7:0]                       swap_count
);

  localparam int unsigned NPIX = BUFFER_WIDTH * BUFFER_HEIGHT;
  localparam int unsigned AW   = $clog2(NPIX);

  fb_state_t     state;
  logic          accept;
  logic          beat_in_range;
  logic          scan_in_range;
  logic [AW-1:0] beat_addr;
  logic [AW-1:0] rd_addr;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  pixel_data_t   wr_data;
  pixel_data_t   rd_data0;
  pixel_data_t   rd_data1;
  logic          rd_valid_q;
  logic          rd_sel_q;
  logic          rd_oob_q;
`ifdef FB_CLEAR_EN
  logic [AW-1:0] clr_addr;
`endif

  assign accept        = pixel_s.valid && pixel_s.ready;
  assign beat_in_range = (32'(pixel_s.metadata.x) < BUFFER_WIDTH) &&
                         (32'(pixel_s.metadata.y) < BUFFER_HEIGHT);
  assign beat_addr     = AW'(32'(pixel_s.metadata.y) * BUFFER_WIDTH + 32'(pixel_s.metadata.x));
  assign scan_in_range = (32'(scan_x) < BUFFER_WIDTH) && (32'(scan_y) < BUFFER_HEIGHT);
  // Out-of-range scans read address 0; the result is masked to CLEAR_COLOR below.
  assign rd_addr       = scan_in_range ? AW'(32'(scan_y) * BUFFER_WIDTH + 32'(scan_x)) : '0;

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    if (!rst) begin
`ifdef FB_CLEAR_EN
      if (state == ST_CLEAR) begin
        wr_en   = 1'b1;
        wr_addr = clr_addr;
        wr_data = CLEAR_COLOR;
      end else
`endif
      if (accept && beat_in_range) begin
        wr_en   = 1'b1;
        wr_addr = beat_addr;
        wr_data = pixel_s.data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      front_sel     <= 1'b0;
      swap_count    <= '0;
      pixel_s.ready <= 1'b0;
`ifdef FB_CLEAR_EN
      state         <= ST_CLEAR;
      clr_addr      <= '0;
`else
      state         <= ST_DRAW;
`endif
    end else begin
      unique case (state)
`ifdef FB_CLEAR_EN
        ST_CLEAR: begin
          if (clr_addr == AW'(NPIX - 1)) begin
            state         <= ST_DRAW;
            pixel_s.ready <= 1'b1;
          end else begin
            clr_addr <= clr_addr + 1'b1;
          end
        end
`endif
        ST_DRAW: begin
          pixel_s.ready <= 1'b1;
          if (accept && pixel_s.metadata.frame_last) begin
            pixel_s.ready <= 1'b0;
            state         <= ST_WAIT_SWAP;
          end
        end
        ST_WAIT_SWAP: begin
          if (vblank_start) begin
            front_sel  <= ~front_sel;
            swap_count <= swap_count + 8'd1;
`ifdef FB_CLEAR_EN
            state      <= ST_CLEAR;
            clr_addr   <= '0;
`else
            state         <= ST_DRAW;
            pixel_s.ready <= 1'b1;
`endif
          end
        end
        default: state <= ST_DRAW;
      endcase
    end
  end

  // Bank select travels with the read address so a swap never redirects a read in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_sel_q   <= 1'b0;
      rd_oob_q   <= 1'b0;
    end else begin
      rd_valid_q <= 1'b1;
      rd_sel_q   <= front_sel;
      rd_oob_q   <= !scan_in_range;
    end
  end

  assign scan_color = !rd_valid_q ? '0 :
                      rd_oob_q    ? CLEAR_COLOR :
                      (rd_sel_q ? rd_data1 : rd_data0);

  fb_bank #(.DEPTH(NPIX), .AW(AW)) u_bank0 (
    .clk     (clk),
    .wr_en   (wr_en && front_sel),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data0)
  );

  fb_bank #(.DEPTH(NPIX), .AW(AW)) u_bank1 (
    .clk     (clk),
    .wr_en   (wr_en && !front_sel),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data1)
  );

endmodule

// File: tb/tb_framebuffer_writer.sv
// Scoreboard bench for framebuffer_writer: random frames against a two-bank array model,
// plus a small instance for swap_count wrap-around. Adapts to FB_CLEAR_EN.
module tb_framebuffer_writer;
  import framebuffer_writer_pkg::*;

  localparam int W = 160;
  localparam int H = 120;
  localparam int N = W * H;
  localparam pixel_data_t CC  = 12'h5A5;
  localparam pixel_data_t SCC = 12'hABC;
`ifdef FB_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, vblank;
  logic [7:0]  sx;
  logic [6:0]  sy;
  pixel_data_t scol;
  logic        fsel;
  logic [7:0]  scnt;
  framebuffer_writer_if bus ();

  framebuffer_writer #(.BUFFER_WIDTH(W), .BUFFER_HEIGHT(H), .CLEAR_COLOR(CC)) dut (
    .clk(clk), .rst(rst), .pixel_s(bus), .vblank_start(vblank),
    .scan_x(sx), .scan_y(sy), .scan_color(scol), .front_sel(fsel), .swap_count(scnt)
  );

  logic        s_rst, s_vb;
  logic [1:0]  s_sx, s_sy;
  pixel_data_t s_col;
  logic        s_fsel;
  logic [7:0]  s_cnt;
  framebuffer_writer_if sbus ();

  framebuffer_writer #(.BUFFER_WIDTH(4), .BUFFER_HEIGHT(3), .CLEAR_COLOR(SCC)) dut_s (
    .clk(clk), .rst(s_rst), .pixel_s(sbus), .vblank_start(s_vb),
    .scan_x(s_sx), .scan_y(s_sy), .scan_color(s_col), .front_sel(s_fsel), .swap_count(s_cnt)
  );

  int checks = 0;
  int fails  = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  // Reference model: contents of both banks, which bank is displayed, swap bookkeeping.
  pixel_data_t mem   [2][N];
  bit          known [2][N];
  int          front, count;
  bit          waiting;

  function automatic void m_fill(int b);
    for (int i = 0; i < N; i++) begin
      mem[b][i]   = CC;
      known[b][i] = 1'b1;
    end
  endfunction

  function automatic void m_reset();
    front   = 0;
    count   = 0;
    waiting = 1'b0;
    if (CLR) m_fill(1);
  endfunction

  function automatic void m_beat(int x, int y, pixel_data_t c, bit last);
    if (x < W && y < H) begin
      mem[1-front][y*W+x]   = c;
      known[1-front][y*W+x] = 1'b1;
    end
    if (last) waiting = 1'b1;
  endfunction

  function automatic void m_vblank();
    if (waiting) begin
      waiting = 1'b0;
      front   = 1 - front;
      count   = (count + 1) % 256;
      if (CLR) m_fill(1 - front);
    end
  endfunction

  typedef struct {
    pixel_data_t exp;
    bit          known;
    int          x;
    int          y;
  } scan_t;

  scan_t sq [$];
  scan_t sc_e;
  logic  scan_req   = 1'b0;
  logic  scan_req_d = 1'b0;

  always @(posedge clk) scan_req_d <= scan_req;

  always @(negedge clk) begin
    if (scan_req_d) begin
      if (sq.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL scan queue underflow: got empty, expected an entry");
      end else begin
        sc_e = sq.pop_front();
        if (sc_e.known) check($sformatf("scan(%0d,%0d)", sc_e.x, sc_e.y), 32'(scol), 32'(sc_e.exp));
      end
    end
  end

  // All tasks start and end on a negedge.
  task automatic scan(input int x, input int y);
    scan_t e;
    sx = 8'(x);
    sy = 7'(y);
    scan_req = 1'b1;
    e.x = x;
    e.y = y;
    if (x >= W || y >= H) begin
      e.exp   = CC;
      e.known = 1'b1;
    end else begin
      e.exp   = mem[front][y*W+x];
      e.known = known[front][y*W+x];
    end
    sq.push_back(e);
    @(negedge clk);
    scan_req = 1'b0;
  endtask

  task automatic send_beat(input int x, input int y, input pixel_data_t c, input bit last,
                           input bit with_vblank);
    int n = 0;
    while (!bus.ready && n < 30000) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("beat (%0d,%0d) accepted", x, y), 32'(bus.ready), 32'd1);
    if (bus.ready) begin
      bus.valid                = 1'b1;
      bus.data                 = c;
      bus.metadata.x           = COORD_W'(x);
      bus.metadata.y           = COORD_W'(y);
      bus.metadata.frame_last  = last;
      vblank                   = with_vblank;
      @(negedge clk);
      bus.valid = 1'b0;
      vblank    = 1'b0;
      // A vblank concurrent with frame_last arrives before WAIT_SWAP, so the model ignores it.
      if (with_vblank) m_vblank();
      m_beat(x, y, c, last);
      if (last) check("ready low in wait_swap", 32'(bus.ready), 32'd0);
    end
  endtask

  task automatic pulse_vblank(input string tag);
    vblank = 1'b1;
    @(negedge clk);
    vblank = 1'b0;
    m_vblank();
    check({tag, " front_sel"}, 32'(fsel), 32'(front));
    check({tag, " swap_count"}, 32'(scnt), 32'(count));
  endtask

  initial begin
    int cyc;
    int qx [$];
    int qy [$];
    int x, y, n;

    rst = 1'b1; vblank = 1'b0; sx = '0; sy = '0;
    bus.valid = 1'b0; bus.data = '0; bus.metadata = '0;
    s_rst = 1'b1; s_vb = 1'b0; s_sx = '0; s_sy = '0;
    sbus.valid = 1'b0; sbus.data = '0; sbus.metadata = '0;
    @(negedge clk);
    @(negedge clk);
    check("reset ready", 32'(bus.ready), 32'd0);
    check("reset front_sel", 32'(fsel), 32'd0);
    check("reset swap_count", 32'(scnt), 32'd0);
    check("reset scan_color", 32'(scol), 32'd0);
    m_reset();
    rst = 1'b0;

    if (CLR) begin
      repeat (5000) @(negedge clk);
      check("ready low mid-clear", 32'(bus.ready), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      m_reset();
    end
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus.ready && cyc < 30000);
    check("cycles until ready", 32'(cyc), CLR ? 32'(N) : 32'd1);

    // Frame A: (0,1) is the alias address of an unfiltered (160,0) write.
    send_beat(0, 1, 12'h00F, 1'b0, 1'b0);
    send_beat(160, 0, 12'h0F0, 1'b0, 1'b0);
    send_beat(3, 2, 12'hF00, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    check("no swap without vblank", 32'(fsel), 32'd0);
    pulse_vblank("swap A");
    scan(3, 2);
    scan(0, 1);
    scan(160, 0);
    scan(0, 0);
    scan(255, 127);
    scan(159, 119);
    pulse_vblank("vblank during clear/draw");

    // Frame B: random beats, stray vblanks, frame_last coincident with vblank.
    for (int i = 0; i < 40; i++) begin
      x = ($urandom_range(0, 9) == 0) ? int'($urandom_range(160, 300)) : int'($urandom_range(0, 159));
      y = ($urandom_range(0, 9) == 0) ? int'($urandom_range(120, 200)) : int'($urandom_range(0, 119));
      send_beat(x, y, pixel_data_t'($urandom), 1'b0, 1'b0);
      if (x < W && y < H) begin
        qx.push_back(x);
        qy.push_back(y);
      end
      if ($urandom_range(0, 7) == 0) pulse_vblank("stray vblank");
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    send_beat(7, 9, 12'h3C3, 1'b1, 1'b1);
    check("coincident vblank front_sel", 32'(fsel), 32'(front));
    check("coincident vblank swap_count", 32'(scnt), 32'(count));
    repeat (4) @(negedge clk);
    pulse_vblank("swap B");
    scan(7, 9);
    foreach (qx[i]) scan(qx[i], qy[i]);
    for (int i = 0; i < 6; i++) scan(int'($urandom_range(0, 255)), int'($urandom_range(0, 127)));
    repeat (3) @(negedge clk);
    check("scan queue drained", 32'(sq.size()), 32'd0);

    // Small instance: 256 swaps wrap swap_count back to 0.
    s_rst = 1'b0;
    for (int i = 0; i < 256; i++) begin
      n = 0;
      while (!sbus.ready && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("small ready", 32'(sbus.ready), 32'd1);
      sbus.valid               = 1'b1;
      sbus.data                = pixel_data_t'(i);
      sbus.metadata.x          = COORD_W'(i % 4);
      sbus.metadata.y          = COORD_W'((i / 4) % 3);
      sbus.metadata.frame_last = 1'b1;
      @(negedge clk);
      sbus.valid = 1'b0;
      s_vb       = 1'b1;
      @(negedge clk);
      s_vb = 1'b0;
      check("small swap_count", 32'(s_cnt), 32'((i + 1) % 256));
    end
    check("swap_count wrapped", 32'(s_cnt), 32'd0);
    check("small front_sel after 256 swaps", 32'(s_fsel), 32'd0);
    s_sx = 2'd3;
    s_sy = 2'd0;
    @(negedge clk);
    check("small last pixel", 32'(s_col), 32'h0FF);
    s_sx = 2'd1;
    s_sy = 2'd3;
    @(negedge clk);
    check("small out-of-range scan", 32'(s_col), 32'(SCC));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
